// File: rtl/wt_lcd_pkg.sv
// Shared types and HD44780 command bytes for the character LCD writer.
package wt_lcd_pkg;

    typedef enum logic [3:0] {
        ST_POWER   = 4'd0,
        ST_FUNC    = 4'd1,
        ST_DISP    = 4'd2,
        ST_ENTRY   = 4'd3,
        ST_CLEAR   = 4'd4,
        ST_CLRWAIT = 4'd5,
        ST_ADDR1   = 4'd6,
        ST_LINE1   = 4'd7,
        ST_ADDR2   = 4'd8,
        ST_LINE2   = 4'd9
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_2L = 8'h38;
    localparam logic [7:0] CMD_FUNC_1L = 8'h30;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_LINE1   = 8'h80;
    localparam logic [7:0] CMD_LINE2   = 8'hC0;

    localparam int LINE_LEN = 16;

endpackage

// File: rtl/wt_lcd_writer_if.sv
// LCD pin bundle: 8-bit data bus plus RS/RW/E control lines.
interface wt_lcd_writer_if;

    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;

    modport master (output LCD_DATA, output LCD_RS, output LCD_RW, output LCD_E);
    modport slave  (input  LCD_DATA, input  LCD_RS, input  LCD_RW, input  LCD_E);

endinterface

// File: rtl/wt_lcd_slot_timer.sv
// Write-slot timer: counts 0..CLK_DIV-1 and decodes load, enable window and slot end.
module wt_lcd_slot_timer #(
    parameter int CLK_DIV = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_load,
    output logic o_e_win,
    output logic o_slot_end
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(1);
    localparam logic [CW-1:0] E_START  = CW'(2);
    localparam logic [CW-1:0] E_STOP   = CW'(CLK_DIV / 2 + 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Enable opens one cycle after the data load, giving the bus a cycle of setup.
    assign o_load     = (r_cnt == CNT_LOAD);
    assign o_e_win    = (r_cnt >= E_START) && (r_cnt < E_STOP);
    assign o_slot_end = (r_cnt == CNT_LAST);

endmodule

// File: rtl/wt_lcd_writer.sv
// HD44780 8-bit write-only driver: one-shot init sequence, then continuous refresh.
// Macro WT_LCD_TWO_LINE_EN enables the second display line (function set 0x38).
module wt_lcd_writer
    import wt_lcd_pkg::*;
#(
    parameter int CLK_DIV     = 2500,
    parameter int POWER_SLOTS = 300,
    parameter int CLEAR_SLOTS = 40
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       BUFF,
    output logic [4:0]       CHAR_IDX,
    output logic             FRAME_DONE,
    wt_lcd_writer_if.master  lcd
);

    localparam int IDLE_W = 16;
    localparam logic [IDLE_W-1:0] POWER_LAST = IDLE_W'(POWER_SLOTS - 1);
    localparam logic [IDLE_W-1:0] CLEAR_LAST = IDLE_W'(CLEAR_SLOTS - 1);
    localparam logic [3:0]        COL_LAST   = 4'(LINE_LEN - 1);
`ifdef WT_LCD_TWO_LINE_EN
    localparam logic [7:0] CMD_FUNC  = CMD_FUNC_2L;
    localparam lcd_state_e LAST_LINE = ST_LINE2;
`else
    localparam logic [7:0] CMD_FUNC  = CMD_FUNC_1L;
    localparam lcd_state_e LAST_LINE = ST_LINE1;
`endif

    logic              w_load;
    logic              w_e_win;
    logic              w_slot_end;
    logic              w_col_last;
    logic              w_write;
    logic              w_rs;
    logic [7:0]        w_byte;
    lcd_state_e        w_state_nxt;
    lcd_state_e        r_state;
    logic [IDLE_W-1:0] r_idle;
    logic [4:0]        r_char_idx;
    logic [7:0]        r_data;
    logic              r_rs;
    logic              r_e;
    logic              r_frame_done;

    wt_lcd_slot_timer #(.CLK_DIV(CLK_DIV)) u_slot_timer (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_load     (w_load),
        .o_e_win    (w_e_win),
        .o_slot_end (w_slot_end)
    );

    assign w_col_last = (r_char_idx[3:0] == COL_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_byte      = 8'h00;
        w_rs        = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_POWER:   if (r_idle == POWER_LAST) w_state_nxt = ST_FUNC;
            ST_FUNC:    begin w_write = 1'b1; w_byte = CMD_FUNC;    w_state_nxt = ST_DISP;    end
            ST_DISP:    begin w_write = 1'b1; w_byte = CMD_DISP_ON; w_state_nxt = ST_ENTRY;   end
            ST_ENTRY:   begin w_write = 1'b1; w_byte = CMD_ENTRY;   w_state_nxt = ST_CLEAR;   end
            ST_CLEAR:   begin w_write = 1'b1; w_byte = CMD_CLEAR;   w_state_nxt = ST_CLRWAIT; end
            ST_CLRWAIT: if (r_idle == CLEAR_LAST) w_state_nxt = ST_ADDR1;
            ST_ADDR1:   begin w_write = 1'b1; w_byte = CMD_LINE1;   w_state_nxt = ST_LINE1;   end
            ST_LINE1: begin
                w_write = 1'b1;
                w_rs    = 1'b1;
                w_byte  = BUFF;
`ifdef WT_LCD_TWO_LINE_EN
                if (w_col_last) w_state_nxt = ST_ADDR2;
`else
                if (w_col_last) w_state_nxt = ST_ADDR1;
`endif
            end
`ifdef WT_LCD_TWO_LINE_EN
            ST_ADDR2:   begin w_write = 1'b1; w_byte = CMD_LINE2;   w_state_nxt = ST_LINE2;   end
            ST_LINE2: begin
                w_write = 1'b1;
                w_rs    = 1'b1;
                w_byte  = BUFF;
                if (w_col_last) w_state_nxt = ST_ADDR1;
            end
`endif
            default:    w_state_nxt = ST_POWER;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_POWER;
            r_idle       <= '0;
            r_char_idx   <= 5'h00;
            r_data       <= 8'h00;
            r_rs         <= 1'b0;
            r_e          <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_load && w_write) begin
                r_data <= w_byte;
                r_rs   <= w_rs;
            end
            r_e          <= w_e_win && w_write;
            r_frame_done <= w_slot_end && (r_state == LAST_LINE) && w_col_last;
            if (w_slot_end) begin
                r_state <= w_state_nxt;
                if (w_state_nxt != r_state) begin
                    r_idle <= '0;
                end else if (r_state == ST_POWER || r_state == ST_CLRWAIT) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
                // Index is set up one slot ahead so it is stable for the whole character slot.
                case (r_state)
                    ST_ADDR1: r_char_idx <= 5'h00;
`ifdef WT_LCD_TWO_LINE_EN
                    ST_ADDR2: r_char_idx <= 5'h10;
                    ST_LINE2: if (!w_col_last) r_char_idx <= r_char_idx + 5'd1;
`endif
                    ST_LINE1: if (!w_col_last) r_char_idx <= r_char_idx + 5'd1;
                    default:  ;
                endcase
            end
        end
    end

    assign CHAR_IDX     = r_char_idx;
    assign FRAME_DONE   = r_frame_done;
    assign lcd.LCD_DATA = r_data;
    assign lcd.LCD_RS   = r_rs;
    assign lcd.LCD_RW   = 1'b0;
    assign lcd.LCD_E    = r_e;

endmodule
